uart_rx_ctrl: RTL and testbench

Parametrised UART receive controller: bit-timing counters, 3-sample majority voter, deserialiser, parity/stop/break checking and the frame state machine in one block.

---
 rtl/uart_rx_ctrl_if.sv | 29 ++
 rtl/uart_rx_ctrl.sv | 263 ++++++++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_if.sv
// Bundle of serial-line, frame-configuration and result signals for the UART receive controller.
// The master side is the host/pad side; the slave side is the controller itself.
interface uart_rx_ctrl_if #(
    parameter int MAX_DATA_W = 9,
    parameter int PRESCALE_W = 6
);
    logic                  RX_IN;
    logic [PRESCALE_W-1:0] PRESCALE;
    logic [3:0]            DATA_LEN;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  STOP2;
    logic [MAX_DATA_W-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  brk_det;
    logic                  busy;

    modport master (
        output RX_IN, PRESCALE, DATA_LEN, PAR_EN, PAR_TYP, STOP2,
        input  P_DATA, data_valid, par_err, stp_err, brk_det, busy
    );

    modport slave (
        input  RX_IN, PRESCALE, DATA_LEN, PAR_EN, PAR_TYP, STOP2,
        output P_DATA, data_valid, par_err, stp_err, brk_det, busy
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: line synchroniser, bit timing, 3-sample majority vote,
// deserialiser, parity/stop/break checks and frame FSM with run-time frame format.
module uart_rx_ctrl #(
    parameter int MAX_DATA_W = 9,
    parameter int PRESCALE_W = 6
) (
    input  logic           CLK,
    input  logic           RST,
    uart_rx_ctrl_if.slave  bus
);

    localparam logic [3:0] MAX_LEN = 4'(MAX_DATA_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_CHECK,
        S_BRK_WAIT
    } state_t;

    state_t                state;
    state_t                next_state;

    logic                  rx_s1;
    logic                  rx_s2;
    logic                  line;

    logic [PRESCALE_W-1:0] p_eff;
    logic [3:0]            len_eff;
    logic [PRESCALE_W-1:0] cfg_p;
    logic [3:0]            cfg_len;
    logic                  cfg_par_en;
    logic                  cfg_par_typ;
    logic                  cfg_stop2;

    logic [PRESCALE_W-1:0] edge_cnt;
    logic [PRESCALE_W-1:0] half;
    logic [3:0]            bit_idx;
    logic [2:0]            smp;
    logic                  voted;
    logic                  vote_pt;
    logic                  bit_end;
    logic                  frame_start;

    logic [MAX_DATA_W-1:0] shift_q;
    logic                  par_flag;
    logic                  stp_flag;
    logic                  par_bit;
    logic                  stop1_bit;
    logic                  is_break;

    logic [MAX_DATA_W-1:0] p_data_q;
    logic                  data_valid_q;
    logic                  par_err_q;
    logic                  stp_err_q;
    logic                  brk_det_q;

    assign line = rx_s2;

    // Effective frame format as it would be latched on the next start bit.
    always_comb begin
        p_eff = {bus.PRESCALE[PRESCALE_W-1:1], 1'b0};
        if (p_eff < PRESCALE_W'(4)) begin
            p_eff = PRESCALE_W'(4);
        end
        len_eff = bus.DATA_LEN;
        if (len_eff < 4'd5) begin
            len_eff = 4'd5;
        end else if (len_eff > MAX_LEN) begin
            len_eff = MAX_LEN;
        end
    end

    always_comb begin
        half    = cfg_p >> 1;
        vote_pt = (edge_cnt == half + PRESCALE_W'(1));
        bit_end = (edge_cnt == cfg_p - PRESCALE_W'(1));
        voted   = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
    end

    always_comb begin
        is_break = (shift_q == '0) && (!cfg_par_en || !par_bit) && !stop1_bit;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (!line) begin
                    next_state = S_START;
                end
            end
            S_START: begin
                if (vote_pt && voted) begin
                    next_state = S_IDLE;
                end else if (bit_end) begin
                    next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end && (bit_idx == cfg_len - 4'd1)) begin
                    next_state = cfg_par_en ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    next_state = S_STOP;
                end
            end
            S_STOP: begin
                // Leave at the vote of the last stop bit, not at its end, to absorb drift.
                if (vote_pt && (bit_idx == {3'b000, cfg_stop2})) begin
                    next_state = S_CHECK;
                end
            end
            S_CHECK: begin
                next_state = is_break ? S_BRK_WAIT : S_IDLE;
            end
            S_BRK_WAIT: begin
                if (line) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign frame_start = (state == S_IDLE) && (next_state == S_START);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            state <= S_IDLE;
        end else begin
            rx_s1 <= bus.RX_IN;
            rx_s2 <= rx_s1;
            state <= next_state;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cfg_p       <= PRESCALE_W'(4);
            cfg_len     <= 4'd5;
            cfg_par_en  <= 1'b0;
            cfg_par_typ <= 1'b0;
            cfg_stop2   <= 1'b0;
        end else if (frame_start) begin
            cfg_p       <= p_eff;
            cfg_len     <= len_eff;
            cfg_par_en  <= bus.PAR_EN;
            cfg_par_typ <= bus.PAR_TYP;
            cfg_stop2   <= bus.STOP2;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            bit_idx  <= '0;
            smp      <= '1;
        end else begin
            if ((state == S_IDLE) || (next_state == S_IDLE) || (next_state == S_CHECK) ||
                (next_state == S_BRK_WAIT) || bit_end) begin
                edge_cnt <= '0;
            end else begin
                edge_cnt <= edge_cnt + PRESCALE_W'(1);
            end

            if (next_state != state) begin
                bit_idx <= '0;
            end else if (bit_end) begin
                bit_idx <= bit_idx + 4'd1;
            end

            if (edge_cnt == half - PRESCALE_W'(2)) begin
                smp[0] <= line;
            end
            if (edge_cnt == half - PRESCALE_W'(1)) begin
                smp[1] <= line;
            end
            if (edge_cnt == half) begin
                smp[2] <= line;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shift_q   <= '0;
            par_flag  <= 1'b0;
            stp_flag  <= 1'b0;
            par_bit   <= 1'b0;
            stop1_bit <= 1'b1;
        end else if (frame_start) begin
            shift_q   <= '0;
            par_flag  <= 1'b0;
            stp_flag  <= 1'b0;
            par_bit   <= 1'b0;
            stop1_bit <= 1'b1;
        end else if (vote_pt) begin
            case (state)
                S_DATA: begin
                    shift_q[bit_idx] <= voted;
                end
                S_PARITY: begin
                    par_bit <= voted;
                    if (voted != ((^shift_q) ^ cfg_par_typ)) begin
                        par_flag <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (!voted) begin
                        stp_flag <= 1'b1;
                    end
                    if (bit_idx == 4'd0) begin
                        stop1_bit <= voted;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            brk_det_q    <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            brk_det_q    <= 1'b0;
            if (state == S_CHECK) begin
                if (is_break) begin
                    brk_det_q <= 1'b1;
                    stp_err_q <= 1'b1;
                end else if (par_flag || stp_flag) begin
                    par_err_q <= par_flag;
                    stp_err_q <= stp_flag;
                end else begin
                    p_data_q     <= shift_q;
                    data_valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.P_DATA     = p_data_q;
    assign bus.data_valid = data_valid_q;
    assign bus.par_err    = par_err_q;
    assign bus.stp_err    = stp_err_q;
    assign bus.brk_det    = brk_det_q;
    assign bus.busy       = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed and randomized frames for uart_rx_ctrl, checked against a frame-level
// model of what each serial frame must produce on the result outputs.
module tb_uart_rx_ctrl;
    localparam int DW = 9;
    localparam int PW = 6;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    uart_rx_ctrl_if #(.MAX_DATA_W(DW), .PRESCALE_W(PW)) bus ();

    uart_rx_ctrl #(.MAX_DATA_W(DW), .PRESCALE_W(PW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    int c_dv = 0;
    int c_pe = 0;
    int c_se = 0;
    int c_bk = 0;
    logic [DW-1:0] dv_log [0:255];

    always @(negedge CLK) begin
        if (bus.data_valid === 1'b1) begin
            dv_log[c_dv[7:0]] <= bus.P_DATA;
            c_dv <= c_dv + 1;
        end
        if (bus.par_err === 1'b1) c_pe <= c_pe + 1;
        if (bus.stp_err === 1'b1) c_se <= c_se + 1;
        if (bus.brk_det === 1'b1) c_bk <= c_bk + 1;
    end

    logic [DW-1:0] exp_pdata = '0;
    int b_dv, b_pe, b_se, b_bk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_p(input int presc);
        int q;
        q = presc & ~1;
        return (q < 4) ? 4 : q;
    endfunction

    function automatic int eff_len(input int dlen);
        if (dlen < 5) return 5;
        if (dlen > DW) return DW;
        return dlen;
    endfunction

    function automatic logic [DW-1:0] len_mask(input int len);
        return DW'((1 << len) - 1);
    endfunction

    task automatic set_cfg(input int presc, input int dlen, input bit pe, input bit pt, input bit s2);
        bus.PRESCALE = PW'(presc);
        bus.DATA_LEN = 4'(dlen);
        bus.PAR_EN   = pe;
        bus.PAR_TYP  = pt;
        bus.STOP2    = s2;
    endtask

    task automatic drive_bit(input logic b, input int p);
        bus.RX_IN = b;
        repeat (p) @(negedge CLK);
    endtask

    task automatic snapshot();
        #1;
        b_dv = c_dv; b_pe = c_pe; b_se = c_se; b_bk = c_bk;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 4000) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic compare(input string tag, input int e_dv, input int e_pe, input int e_se, input int e_bk);
        repeat (3) @(negedge CLK);
        #1;
        check({tag, "_dv"},  32'(c_dv - b_dv), 32'(e_dv));
        check({tag, "_pe"},  32'(c_pe - b_pe), 32'(e_pe));
        check({tag, "_se"},  32'(c_se - b_se), 32'(e_se));
        check({tag, "_bk"},  32'(c_bk - b_bk), 32'(e_bk));
        check({tag, "_pdata"}, 32'(bus.P_DATA), 32'(exp_pdata));
    endtask

    // Serialises one frame; mid-frame the config inputs are scrambled, which must not matter.
    task automatic send_frame(input logic [DW-1:0] d, input int len, input int p, input bit pe,
                              input bit pt, input bit s2, input bit pflip, input bit st1,
                              input bit st2, input int spike);
        logic [DW-1:0] dm;
        logic pb;
        dm = d & len_mask(len);
        pb = (^dm) ^ pt ^ pflip;
        drive_bit(1'b0, p);
        check("busy_in_frame", 32'(bus.busy), 32'd1);
        set_cfg($urandom_range(0, 63), $urandom_range(0, 15), 1'($urandom), 1'($urandom), 1'($urandom));
        for (int i = 0; i < len; i++) begin
            if (i == spike) begin
                bus.RX_IN = dm[i];
                repeat (8) @(negedge CLK);
                bus.RX_IN = 1'b0;
                @(negedge CLK);
                bus.RX_IN = dm[i];
                repeat (p - 9) @(negedge CLK);
            end else begin
                drive_bit(dm[i], p);
            end
        end
        if (pe) drive_bit(pb, p);
        drive_bit(st1, p);
        if (s2) drive_bit(st2, p);
    endtask

    // Frame-level reference: what a receiver must report for this frame.
    task automatic run_frame(input string tag, input logic [DW-1:0] d, input int presc, input int dlen,
                             input bit pe, input bit pt, input bit s2, input bit pflip,
                             input bit st1, input bit st2, input int spike);
        int p, len;
        logic [DW-1:0] dm;
        logic pb;
        bit brk, perr, serr;
        p   = eff_p(presc);
        len = eff_len(dlen);
        dm  = d & len_mask(len);
        pb  = (^dm) ^ pt ^ pflip;
        brk  = (dm == '0) && (!pe || !pb) && !st1;
        perr = pe && pflip;
        serr = !st1 || (s2 && !st2);
        set_cfg(presc, dlen, pe, pt, s2);
        snapshot();
        send_frame(d, len, p, pe, pt, s2, pflip, st1, st2, spike);
        drive_bit(1'b1, 2 * p);
        wait_idle(tag);
        if (brk) begin
            compare(tag, 0, 0, 1, 1);
        end else if (perr || serr) begin
            compare(tag, 0, perr ? 1 : 0, serr ? 1 : 0, 0);
        end else begin
            exp_pdata = dm;
            compare(tag, 1, 0, 0, 0);
        end
    endtask

    initial begin
        bus.RX_IN = 1'b1;
        set_cfg(8, 8, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge CLK);
        #1;
        check("rst_pdata", 32'(bus.P_DATA), 32'd0);
        check("rst_dv",    32'(bus.data_valid), 32'd0);
        check("rst_pe",    32'(bus.par_err), 32'd0);
        check("rst_se",    32'(bus.stp_err), 32'd0);
        check("rst_bk",    32'(bus.brk_det), 32'd0);
        check("rst_busy",  32'(bus.busy), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        repeat (4) @(negedge CLK);

        run_frame("a5_even", 9'h0A5, 8, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        run_frame("55_badpar", 9'h055, 16, 7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, -1);

        set_cfg(8, 8, 1'b0, 1'b0, 1'b0);
        snapshot();
        bus.RX_IN = 1'b0;
        repeat (3) @(negedge CLK);
        bus.RX_IN = 1'b1;
        wait_idle("glitch");
        compare("glitch", 0, 0, 0, 0);

        run_frame("3c_stop2bad", 9'h03C, 8, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, -1);

        set_cfg(8, 8, 1'b0, 1'b0, 1'b1);
        snapshot();
        send_frame(9'h03C, 8, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, -1);
        set_cfg(8, 8, 1'b0, 1'b0, 1'b1);
        send_frame(9'h0C3, 8, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, -1);
        drive_bit(1'b1, 16);
        wait_idle("b2b");
        exp_pdata = 9'h0C3;
        compare("b2b", 2, 0, 0, 0);
        check("b2b_first",  32'(dv_log[b_dv[7:0]]), 32'h03C);
        check("b2b_second", 32'(dv_log[8'(b_dv + 1)]), 32'h0C3);

        set_cfg(8, 8, 1'b1, 1'b0, 1'b0);
        snapshot();
        drive_bit(1'b0, 20 * 8);
        check("brk_busy_low", 32'(bus.busy), 32'd1);
        bus.RX_IN = 1'b1;
        wait_idle("brk");
        compare("brk", 0, 0, 1, 1);
        run_frame("81_after_brk", 9'h081, 8, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);

        run_frame("ff_spike", 9'h0FF, 16, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3);

        run_frame("len_lo_clamp", 9'h1F5, 8, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        run_frame("len_hi_clamp", 9'h1A7, 8, 15, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        run_frame("presc_odd", 9'h0B6, 5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        run_frame("presc_zero", 9'h04D, 0, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, -1);

        // Reset in the middle of the data field of a good frame.
        run_frame("pre_reset", 9'h1E1, 8, 9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        set_cfg(8, 8, 1'b0, 1'b0, 1'b0);
        snapshot();
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 8 * 3 + 4);
        RST = 1'b0;
        #1;
        check("midrst_pdata", 32'(bus.P_DATA), 32'd0);
        check("midrst_busy",  32'(bus.busy), 32'd0);
        check("midrst_dv",    32'(bus.data_valid), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        exp_pdata = '0;
        repeat (10 * 8) @(negedge CLK);
        wait_idle("midrst");
        compare("midrst", 0, 0, 0, 0);

        for (int k = 0; k < 25; k++) begin
            run_frame("rand", 9'($urandom), $urandom_range(0, 30), $urandom_range(0, 15),
                      1'($urandom), 1'($urandom), 1'($urandom),
                      $urandom_range(0, 7) == 0, $urandom_range(0, 7) != 0,
                      $urandom_range(0, 7) != 0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
